// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA capture unit.
//   cap_state_t : capture controller states
//   SOL_OFS/SOF_OFS : bit offsets of the sol/sof flags above the pixel field
//                     in a record laid out as {sof, sol, pixel}
package vga_capture_pkg;
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_CAPTURE    = 2'd2,
    ST_DONE       = 2'd3
  } cap_state_t;

  localparam int SOL_OFS = 0;
  localparam int SOF_OFS = 1;
endpackage

// File: rtl/capture_fifo.sv
// Synchronous record FIFO for the capture unit.
//   clk, rst_n     : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata    : write request and record
//   pop            : read request (ignored when empty)
//   rdata          : head record, 0 when empty
//   full, empty    : occupancy flags
// A push while full succeeds only if a pop frees the head slot in the same cycle.
module capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/vga_capture_unit.sv
// VGA pixel capture: decimates the visible pixel stream, tags records with
// start-of-frame / start-of-line flags and buffers them in a FIFO.
//   FPGA_Clock, FPGA_Reset_N : clock, synchronous active-low reset
//   pixel_in, visible, VGA_VS: video input (VS active low)
//   capture_en, single_shot  : arm/run control, mode latched while idle
//   out_data/out_valid/out_ready : record stream {sof, sol, pixel}
//   busy, done, overflow, drop_count, frame_count : status
module vga_capture_unit
  import vga_capture_pkg::*;
#(
  parameter int COLOR_W  = 8,
  parameter int CHANNELS = 3,
  parameter int DECIM    = 4,
  parameter int DEPTH    = 16
) (
  input  logic                            FPGA_Clock,
  input  logic                            FPGA_Reset_N,
  input  logic [CHANNELS*COLOR_W-1:0]     pixel_in,
  input  logic                            visible,
  input  logic                            VGA_VS,
  input  logic                            capture_en,
  input  logic                            single_shot,
  output logic [CHANNELS*COLOR_W+2-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [15:0]                     drop_count,
  output logic [15:0]                     frame_count
);
  localparam int PW = CHANNELS*COLOR_W;
  localparam int RW = PW + 2;
  localparam logic [7:0] DLAST = 8'(DECIM - 1);

  cap_state_t state, next_state;
  logic       vs_q, vis_q, mode_ss;
  logic       fs, ls;
  logic       arm, enter_cap, fs_cont;
  logic [7:0] dec_cnt, cnt_cur;
  logic       hit, sample, sof_pend, sol_pend, sof, sol;
  logic [RW-1:0] rec, wr_data_q;
  logic       wr_q, pop, full, empty, drop;

  assign fs = vs_q && !VGA_VS;
  assign ls = visible && !vis_q;

  // state register
  always_ff @(posedge FPGA_Clock) begin
    if (!FPGA_Reset_N) state <= ST_IDLE;
    else               state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (capture_en) next_state = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (!capture_en) next_state = ST_IDLE;
                     else if (fs)     next_state = ST_CAPTURE;
      ST_CAPTURE:    if (!capture_en)      next_state = ST_IDLE;
                     else if (fs && mode_ss) next_state = ST_DONE;
      ST_DONE:       if (!capture_en) next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // state-derived outputs and events
  always_comb begin
    busy      = (state == ST_WAIT_FRAME) || (state == ST_CAPTURE);
    done      = (state == ST_DONE);
    arm       = (state == ST_IDLE) && capture_en;
    enter_cap = (state == ST_WAIT_FRAME) && capture_en && fs;
    // In single-shot mode the closing frame start ends capture, so it
    // neither starts a new frame record nor counts as a captured frame.
    fs_cont   = (state == ST_CAPTURE) && capture_en && fs && !mode_ss;
  end

  // Decimation: the line-start cycle counts as visible cycle 1 (index 0).
  assign cnt_cur = ls ? 8'd0 : dec_cnt;
  assign hit     = visible && (cnt_cur == DLAST);
  assign sample  = hit && (state == ST_CAPTURE);
  assign sof     = sof_pend || fs_cont;
  assign sol     = sol_pend || ls;

  always_comb begin
    rec              = '0;
    rec[PW-1:0]      = pixel_in;
    rec[PW+SOF_OFS]  = sof;
    rec[PW+SOL_OFS]  = sol;
  end

  always_ff @(posedge FPGA_Clock) begin
    if (!FPGA_Reset_N) begin
      vs_q      <= 1'b0;
      vis_q     <= 1'b0;
      mode_ss   <= 1'b0;
      dec_cnt   <= '0;
      sof_pend  <= 1'b0;
      sol_pend  <= 1'b0;
      wr_q      <= 1'b0;
      wr_data_q <= '0;
    end else begin
      vs_q  <= VGA_VS;
      vis_q <= visible;
      if (state == ST_IDLE) mode_ss <= single_shot;
      if (visible) dec_cnt <= hit ? 8'd0 : cnt_cur + 8'd1;
      if (sample)                    sof_pend <= 1'b0;
      else if (enter_cap || fs_cont) sof_pend <= 1'b1;
      if (sample)  sol_pend <= 1'b0;
      else if (ls) sol_pend <= 1'b1;
      // one-cycle staging register between sample and FIFO write
      wr_q      <= sample;
      wr_data_q <= rec;
    end
  end

  assign pop  = out_valid && out_ready;
  assign drop = wr_q && full && !pop;

  always_ff @(posedge FPGA_Clock) begin
    if (!FPGA_Reset_N || arm) begin
      overflow    <= 1'b0;
      drop_count  <= '0;
      frame_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (enter_cap || fs_cont) frame_count <= frame_count + 16'd1;
    end
  end

  capture_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk   (FPGA_Clock),
    .rst_n (FPGA_Reset_N),
    .push  (wr_q),
    .wdata (wr_data_q),
    .pop   (pop),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = !empty;
endmodule

// File: tb/tb_vga_capture_unit.sv
// Directed bench for vga_capture_unit (COLOR_W=8, CHANNELS=3, DECIM=4, DEPTH=16).
module tb_vga_capture_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pixel_in;
  logic        visible, vs, capture_en, single_shot, out_ready;
  logic [25:0] out_data;
  logic        out_valid, busy, done, overflow;
  logic [15:0] drop_count, frame_count;

  int total = 0;
  int bad   = 0;
  logic [25:0] rq[$];

  typedef struct {
    int          nvis;
    logic [23:0] base;
    int          exp_recs;
  } line_vec_t;

  vga_capture_unit #(.COLOR_W(8), .CHANNELS(3), .DECIM(4), .DEPTH(16)) dut (
    .FPGA_Clock(clk), .FPGA_Reset_N(rst_n), .pixel_in(pixel_in), .visible(visible),
    .VGA_VS(vs), .capture_en(capture_en), .single_shot(single_shot),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow), .drop_count(drop_count),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees what the next edge pops.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) rq.push_back(out_data);

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_capture(input logic ss);
    capture_en = 1'b0; vs = 1'b1; visible = 1'b0;
    cyc(2);
    single_shot = ss; capture_en = 1'b1;
    cyc(2);
    vs = 1'b0; cyc(1);
    vs = 1'b1; cyc(1);
  endtask

  task automatic vs_edge();
    vs = 1'b0; cyc(1);
    vs = 1'b1; cyc(1);
  endtask

  // pixel on visible cycle i (1-based) is base+i
  task automatic drive_line(input int n, input logic [23:0] base);
    for (int i = 1; i <= n; i++) begin
      visible = 1'b1; pixel_in = base + 24'(i);
      cyc(1);
    end
    visible = 1'b0;
    cyc(1);
  endtask

  initial begin
    line_vec_t vecs[5];
    int errs, sofs;
    vecs[0] = '{640, 24'h000000, 160};
    vecs[1] = '{3,   24'h010000, 0};
    vecs[2] = '{4,   24'h020000, 1};
    vecs[3] = '{7,   24'h030000, 1};
    vecs[4] = '{9,   24'h040000, 2};

    rst_n = 1'b0; pixel_in = '0; visible = 1'b0; vs = 1'b1;
    capture_en = 1'b0; single_shot = 1'b0; out_ready = 1'b0;
    cyc(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    cyc(1);

    // table: decimation per line length
    for (int v = 0; v < 5; v++) begin
      start_capture(1'b0);
      out_ready = 1'b1;
      rq.delete();
      drive_line(vecs[v].nvis, vecs[v].base);
      cyc(6);
      check($sformatf("line%0d_count", v), rq.size(), vecs[v].exp_recs);
      errs = 0;
      foreach (rq[k]) begin
        if (rq[k][23:0] !== vecs[v].base + 24'(4*(k+1))) errs++;
        if (rq[k][24] !== (k == 0)) errs++;
      end
      check($sformatf("line%0d_records", v), errs, 0);
      if (vecs[v].exp_recs > 0) check($sformatf("line%0d_sof", v), rq[0][25], 1);
    end

    // latency: sample at 4th visible cycle, out_valid two edges later, data held
    start_capture(1'b0);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      visible = 1'b1; pixel_in = 24'h0A0000 + 24'(i); cyc(1);
    end
    check("lat_valid_early", out_valid, 0);
    visible = 1'b0; cyc(1);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, {2'b11, 24'h0A0004});
    cyc(3);
    check("hold_data", out_data, {2'b11, 24'h0A0004});
    out_ready = 1'b1; cyc(3);
    check("lat_drained", out_valid, 0);

    // overflow: 20 samples into 16 slots, then push+pop while full
    start_capture(1'b0);
    out_ready = 1'b0;
    rq.delete();
    drive_line(80, 24'h000100);
    cyc(3);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_count, 4);
    for (int i = 1; i <= 4; i++) begin
      visible = 1'b1; pixel_in = 24'h000800 + 24'(i); cyc(1);
    end
    visible = 1'b0; out_ready = 1'b1; cyc(1);
    out_ready = 1'b0; cyc(2);
    check("full_pushpop_drops", drop_count, 4);
    out_ready = 1'b1; cyc(24);
    check("full_occupancy", rq.size(), 17);
    errs = 0;
    for (int k = 0; k < 16 && k < rq.size(); k++)
      if (rq[k][23:0] !== 24'h000100 + 24'(4*(k+1))) errs++;
    if (rq.size() == 17 && rq[16][23:0] !== 24'h000804) errs++;
    check("ovf_order", errs, 0);

    // single shot: second frame start ends capture
    start_capture(1'b1);
    check("ss_busy", busy, 1);
    out_ready = 1'b1;
    rq.delete();
    drive_line(8, 24'h000300);
    vs_edge();
    check("ss_done", done, 1);
    check("ss_not_busy", busy, 0);
    check("ss_frames", frame_count, 1);
    drive_line(8, 24'h000400);
    cyc(4);
    check("ss_records", rq.size(), 2);
    if (rq.size() > 0) check("ss_sof", rq[0][25], 1);
    capture_en = 1'b0; cyc(1);
    check("ss_idle", done, 0);

    // continuous over three frames, records survive leaving capture
    start_capture(1'b0);
    out_ready = 1'b0;
    rq.delete();
    drive_line(8, 24'h000500);
    vs_edge();
    drive_line(8, 24'h000600);
    vs_edge();
    drive_line(8, 24'h000700);
    cyc(2);
    check("cont_frames", frame_count, 3);
    capture_en = 1'b0; cyc(2);
    check("cont_idle", busy, 0);
    check("cont_valid_idle", out_valid, 1);
    out_ready = 1'b1; cyc(10);
    check("cont_records", rq.size(), 6);
    sofs = 0;
    foreach (rq[k]) if (rq[k][25]) sofs++;
    check("cont_sof_count", sofs, 3);

    // reset mid-line with five records buffered
    start_capture(1'b0);
    out_ready = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      visible = 1'b1; pixel_in = 24'h000900 + 24'(i); cyc(1);
    end
    check("mid_frames_pre", frame_count, 1);
    rst_n = 1'b0; capture_en = 1'b0; cyc(1);
    check("mid_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_frames", frame_count, 0);
    check("mid_drops", drop_count, 0);
    check("mid_out_data", out_data, 0);
    rst_n = 1'b1; visible = 1'b0; cyc(3);
    check("mid_no_partial", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_capture_unit.md
VGA_CAPTURE_UNIT -- requirements
Module: vga_capture_unit

Interface
REQ-001 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter CHANNELS, default 3, colour channels per pixel.
REQ-003 SHALL have parameter DECIM, default 4, range 1..255; one sample kept per DECIM visible cycles.
REQ-004 SHALL have parameter DEPTH, default 16, power of two >= 2; record FIFO depth.
REQ-005 SHALL use one clock and a synchronous, active-low reset: FPGA_Clock and FPGA_Reset_N.
REQ-006 SHALL have ports FPGA_Clock  in  1  system clock; FPGA_Reset_N  in  1  synchronous active-low reset.
REQ-007 SHALL have ports pixel_in  in  CHANNELS*COLOR_W  packed pixel, channel 0 in the LSBs; visible  in  1  active-video qualifier; VGA_VS  in  1  vertical sync, active low.
REQ-008 SHALL have ports capture_en  in  1  arm/run; single_shot  in  1  1 = one frame, 0 = continuous; sampled only in IDLE.
REQ-009 SHALL have ports out_data  out  CHANNELS*COLOR_W+2  record {sof, sol, pixel}; out_valid  out  1; out_ready  in  1.
REQ-010 SHALL have ports busy  out  1  state is WAIT_FRAME or CAPTURE; done  out  1  single-shot complete; overflow  out  1  sticky drop flag; drop_count  out  16  dropped samples; frame_count  out  16  frames captured.

Function
REQ-011 SHALL implement states IDLE, WAIT_FRAME, CAPTURE, DONE.
REQ-012 Transitions: IDLE->WAIT_FRAME on capture_en=1; WAIT_FRAME->CAPTURE on frame start; in single-shot mode, CAPTURE->DONE on the next frame start; DONE->IDLE on capture_en=0; any state except IDLE -> IDLE on capture_en=0.
REQ-013 Frame start SHALL be a registered falling edge of VGA_VS (previous 1, current 0); line start SHALL be a registered rising edge of visible.
REQ-014 Decimation counter SHALL clear to 0 on line start and increment on every visible=1 cycle; a sample SHALL occur when the counter equals DECIM-1, after which it returns to 0; the first sample of a line is therefore the DECIM-th visible cycle.
REQ-015 Samples SHALL be generated only in CAPTURE.
REQ-016 sof SHALL be 1 on the first sample after entering CAPTURE and after each frame start in continuous mode.
REQ-017 sol SHALL be 1 on the first sample of each line.
REQ-018 A sample SHALL be written to the FIFO on the cycle after it occurs; out_valid SHALL rise on the following edge (2-cycle latency from sample to out_valid with an empty FIFO).
REQ-019 out_valid SHALL equal FIFO not-empty; a record pops on out_valid & out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 When the FIFO is full, a write SHALL succeed if a pop occurs in the same cycle; otherwise the sample is dropped, overflow is set, and drop_count increments, saturating at 16'hFFFF.
REQ-021 Simultaneous push and pop with an empty FIFO SHALL be a push only; out_valid rises on the next cycle.
REQ-022 frame_count SHALL increment on each frame start that occurs in CAPTURE or on WAIT_FRAME->CAPTURE, wrapping modulo 2^16.
REQ-023 overflow, drop_count and frame_count SHALL clear on IDLE->WAIT_FRAME.
REQ-024 Leaving CAPTURE SHALL NOT flush the FIFO; buffered records stay poppable.
REQ-025 done SHALL be 1 only in DONE.

Reset
REQ-026 When FPGA_Reset_N=0 at a clock edge: state IDLE; FIFO empty; all counters, flags, edge registers and outputs 0 (out_data 0).
REQ-027 Reset mid-capture SHALL discard FIFO contents, with no partial record emitted.

Structure
REQ-028 The shared package vga_capture_pkg SHALL hold the state enum and the sof/sol bit-offset constants.
REQ-029 The FIFO SHALL be a sub-module, capture_fifo (parameters WIDTH and DEPTH, with full/empty flags and pointer wrap), instantiated once.

Verification
REQ-030 Verification: DECIM=4, one 640-cycle visible line in CAPTURE with out_ready=1 -> 160 records; the first has sol=1; samples are at visible cycles 4, 8, ..., 640.
REQ-031 Verification: single_shot=1, capture_en=1, then two VS falling edges -> busy, then done=1 after the second edge; the first record has sof=1; frame_count=1; no records follow the second edge.
REQ-032 Verification: DEPTH=16, out_ready=0, 20 samples -> exactly 16 records held, overflow=1, drop_count=4; drained records are the first 16 in order.
REQ-033 Verification: FIFO full with out_ready=1 and a sample in the same cycle -> no drop; drop_count unchanged; occupancy stays 16.
REQ-034 Verification: FPGA_Reset_N=0 for 1 cycle mid-line with 5 records buffered -> next cycle out_valid=0, state IDLE, all counters 0.
REQ-035 Verification: continuous mode across 3 frames -> sof=1 on exactly 3 records; frame_count=3; capture_en=0 -> IDLE with remaining records still drained.
